// File: rtl/watchdog_multistage.sv
// Multi-output watchdog on the shared 5-bit CSR bus: windowed kicks, pre-timeout
// interrupt, W1C status, and a failsafe mode in which the counter survives reset.
module watchdog_multistage #(
  parameter logic [4:0]           BASE_ADDR       = 5'h0,
  parameter int                   CNT_WIDTH       = 16,
  parameter int                   NUM_OUT         = 2,
  parameter logic [NUM_OUT-1:0]   DEFAULT_OE      = '0,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_TIMEOUT = '1,
  parameter logic [7:0]           KICK_VALUE      = 8'h6b
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [4:0]         csr_a,
  input  logic [7:0]         csr_di,
  input  logic               csr_we,
  output logic [7:0]         csr_do,
  input  logic [1:0]         wdt_en_default,
  output logic [NUM_OUT-1:0] wdt_out,
  output logic [NUM_OUT-1:0] wdt_out_strobe,
  output logic               force_recovery_mode,
  output logic               irq
);

  localparam logic [4:0] OFF_CTRL    = 5'd0;
  localparam logic [4:0] OFF_TOUT_L  = 5'd1;
  localparam logic [4:0] OFF_TOUT_H  = 5'd2;
  localparam logic [4:0] OFF_KICK    = 5'd3;
  localparam logic [4:0] OFF_CNT_L   = 5'd4;
  localparam logic [4:0] OFF_CNT_H   = 5'd5;
  localparam logic [4:0] OFF_PRETOUT = 5'd6;
  localparam logic [4:0] OFF_WINDOW  = 5'd7;
  localparam logic [4:0] OFF_STATUS  = 5'd8;

  logic [1:0]           r_en;
  logic                 r_locked;
  logic                 r_win_en;
  logic [NUM_OUT-1:0]   r_oe;
  logic [CNT_WIDTH-1:0] r_tout;
  logic [7:0]           r_stage;
  logic [7:0]           r_pretout;
  logic [7:0]           r_window;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_status;
  logic                 r_bite_d;

  logic [4:0]           w_off;
  logic                 w_wr_cfg;
  logic                 w_active;
  logic                 w_bite;
  logic                 w_kick;
  logic                 w_early;
  logic                 w_reload;
  logic                 w_dec;
  logic                 w_pre;
  logic                 w_bite_rise;
  logic [CNT_WIDTH:0]   w_pre_ext;
  logic [2:0]           w_status_set;
  logic [2:0]           w_status_clr;
  logic [3:0]           w_oe4;
  logic [15:0]          w_cnt16;
  logic [15:0]          w_tout16;

  assign w_off    = csr_a - BASE_ADDR;
  assign w_wr_cfg = csr_we & ~r_locked;
  assign w_active = |r_en;
  assign w_bite   = w_active & (r_cnt == '0);
  assign w_kick   = csr_we & (w_off == OFF_KICK) & (csr_di == KICK_VALUE);
  assign w_early  = w_kick & r_win_en & w_active & (r_cnt > CNT_WIDTH'(r_window));
  assign w_reload = rst & ~r_en[1];
  // Decrement only when no higher-priority counter update is taking place.
  assign w_dec    = ce & w_active & ~w_bite & ~w_kick & ~w_reload;

  // Widened compare so PRETOUT=0xFF cannot alias when CNT_WIDTH is 8.
  assign w_pre_ext    = (CNT_WIDTH+1)'(r_pretout) + (CNT_WIDTH+1)'(1);
  assign w_pre        = w_dec & (r_pretout != 8'd0) & ({1'b0, r_cnt} == w_pre_ext);
  assign w_bite_rise  = w_bite & ~r_bite_d;
  assign w_status_set = {w_early, w_bite_rise, w_pre};
  assign w_status_clr = (csr_we && (w_off == OFF_STATUS)) ? csr_di[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (w_reload)     r_cnt <= DEFAULT_TIMEOUT;
    else if (w_early) r_cnt <= '0;
    else if (w_kick)  r_cnt <= r_tout;
    else if (w_dec)   r_cnt <= r_cnt - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= wdt_en_default;
      r_locked  <= 1'b0;
      r_win_en  <= 1'b0;
      r_oe      <= DEFAULT_OE;
      r_tout    <= DEFAULT_TIMEOUT;
      r_stage   <= 8'd0;
      r_pretout <= 8'd0;
      r_window  <= 8'd0;
    end else if (w_wr_cfg) begin
      case (w_off)
        OFF_CTRL: begin
          r_en     <= csr_di[1:0];
          r_locked <= csr_di[2];
          r_win_en <= csr_di[3];
          r_oe     <= csr_di[4 +: NUM_OUT];
        end
        OFF_TOUT_L: begin
          if (CNT_WIDTH == 16) r_stage <= csr_di;
          else                 r_tout  <= CNT_WIDTH'(csr_di);
        end
        OFF_TOUT_H: begin
          if (CNT_WIDTH == 16) r_tout <= CNT_WIDTH'({csr_di, r_stage});
        end
        OFF_PRETOUT: r_pretout <= csr_di;
        OFF_WINDOW:  r_window  <= csr_di;
        default: ;
      endcase
    end
  end

  // A set event in the same cycle wins over a W1C clear of that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= 3'b000;
      r_bite_d <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_status_set;
      r_bite_d <= w_bite;
    end
  end

  assign w_oe4    = 4'(r_oe);
  assign w_cnt16  = 16'(r_cnt);
  assign w_tout16 = 16'(r_tout);

  always_comb begin
    csr_do = 8'd0;
    case (w_off)
      OFF_CTRL:    csr_do = {w_oe4, r_win_en, r_locked, r_en};
      OFF_TOUT_L:  csr_do = w_tout16[7:0];
      OFF_TOUT_H:  csr_do = w_tout16[15:8];
      OFF_CNT_L:   csr_do = w_cnt16[7:0];
      OFF_CNT_H:   csr_do = w_cnt16[15:8];
      OFF_PRETOUT: csr_do = r_pretout;
      OFF_WINDOW:  csr_do = r_window;
      OFF_STATUS:  csr_do = {5'b00000, r_status};
      default:     csr_do = 8'd0;
    endcase
  end

  assign wdt_out             = r_oe & {NUM_OUT{w_bite}};
  assign wdt_out_strobe      = r_oe & {NUM_OUT{w_bite_rise}};
  assign force_recovery_mode = w_bite & r_en[1];
  assign irq                 = |r_status;

endmodule

// File: tb/tb_watchdog_multistage.sv
// Bench for watchdog_multistage: directed scenarios with literal expectations,
// then random CSR/tick traffic compared every cycle against a behavioural model.
module tb_watchdog_multistage;

  localparam logic [4:0]  TB_BASE = 5'h04;
  localparam int          TB_DEF  = 16'h0030;
  localparam logic [7:0]  TB_KICK = 8'h6b;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic [1:0] wdt_en_default;
  logic [1:0] wdt_out;
  logic [1:0] wdt_out_strobe;
  logic       force_recovery_mode;
  logic       irq;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  watchdog_multistage #(
    .BASE_ADDR(TB_BASE), .CNT_WIDTH(16), .NUM_OUT(2), .DEFAULT_OE(2'b00),
    .DEFAULT_TIMEOUT(16'h0030), .KICK_VALUE(TB_KICK)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .csr_a(csr_a), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do), .wdt_en_default(wdt_en_default),
    .wdt_out(wdt_out), .wdt_out_strobe(wdt_out_strobe),
    .force_recovery_mode(force_recovery_mode), .irq(irq)
  );

  // ---------------- clock / safety bound ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time bound reached");
  end

  // ---------------- behavioural model ----------------
  // Registers kept as plain integers; next state derived from the register-map rules.
  bit [1:0] m_en;
  bit       m_locked, m_win_en;
  bit [1:0] m_oe;
  int       m_tout, m_stage, m_cnt, m_pre, m_win;
  bit [2:0] m_status;
  bit       m_bite_d;

  bit [1:0] n_en;
  bit       n_locked, n_win_en;
  bit [1:0] n_oe;
  int       n_tout, n_stage, n_cnt, n_pre, n_win;
  bit [2:0] n_status;
  bit       n_bite_d;

  logic [4:0] t_off;
  bit         t_active, t_bite, t_kick, t_early, t_pre;
  bit [2:0]   t_clr;
  logic [1:0] e_out, e_strobe;
  logic       e_frm, e_irq;
  logic [7:0] e_do;

  initial begin
    m_en = 2'b00; m_locked = 1'b0; m_win_en = 1'b0; m_oe = 2'b00;
    m_tout = TB_DEF; m_stage = 0; m_cnt = TB_DEF; m_pre = 0; m_win = 0;
    m_status = 3'b000; m_bite_d = 1'b0;
  end

  always_comb begin
    n_en = m_en; n_locked = m_locked; n_win_en = m_win_en; n_oe = m_oe;
    n_tout = m_tout; n_stage = m_stage; n_cnt = m_cnt; n_pre = m_pre; n_win = m_win;
    n_status = m_status; n_bite_d = m_bite_d;
    t_off    = csr_a - TB_BASE;
    t_active = (m_en != 2'b00);
    t_bite   = t_active && (m_cnt == 0);
    t_kick   = csr_we && (t_off == 5'd3) && (csr_di == TB_KICK);
    t_early  = t_kick && m_win_en && t_active && (m_cnt > m_win);
    t_pre    = 1'b0;
    t_clr    = (csr_we && t_off == 5'd8) ? csr_di[2:0] : 3'b000;
    if (rst && !m_en[1]) n_cnt = TB_DEF;
    else if (t_early)    n_cnt = 0;
    else if (t_kick)     n_cnt = m_tout;
    else if (ce && t_active && !t_bite) begin
      n_cnt = m_cnt - 1;
      t_pre = (m_pre != 0) && (n_cnt == m_pre);
    end
    if (rst) begin
      n_status = 3'b000; n_bite_d = 1'b0;
      n_en = wdt_en_default; n_locked = 1'b0; n_win_en = 1'b0; n_oe = 2'b00;
      n_tout = TB_DEF; n_stage = 0; n_pre = 0; n_win = 0;
    end else begin
      n_status = (m_status & ~t_clr) | {t_early, t_bite && !m_bite_d, t_pre};
      n_bite_d = t_bite;
      if (csr_we && !m_locked) begin
        case (t_off)
          5'd0: begin
            n_en = csr_di[1:0]; n_locked = csr_di[2]; n_win_en = csr_di[3]; n_oe = csr_di[5:4];
          end
          5'd1: n_stage = int'(csr_di);
          5'd2: n_tout = int'(csr_di) * 256 + m_stage;
          5'd6: n_pre = int'(csr_di);
          5'd7: n_win = int'(csr_di);
          default: ;
        endcase
      end
    end
    e_out    = t_bite ? m_oe : 2'b00;
    e_strobe = (t_bite && !m_bite_d) ? m_oe : 2'b00;
    e_frm    = t_bite && m_en[1];
    e_irq    = (m_status != 3'b000);
    case (t_off)
      5'd0:    e_do = {2'b00, m_oe, m_win_en, m_locked, m_en};
      5'd1:    e_do = 8'(m_tout);
      5'd2:    e_do = 8'(m_tout / 256);
      5'd4:    e_do = 8'(m_cnt);
      5'd5:    e_do = 8'(m_cnt / 256);
      5'd6:    e_do = 8'(m_pre);
      5'd7:    e_do = 8'(m_win);
      5'd8:    e_do = {5'b00000, m_status};
      default: e_do = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    m_en <= n_en; m_locked <= n_locked; m_win_en <= n_win_en; m_oe <= n_oe;
    m_tout <= n_tout; m_stage <= n_stage; m_cnt <= n_cnt; m_pre <= n_pre; m_win <= n_win;
    m_status <= n_status; m_bite_d <= n_bite_d;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_wdt_out", 16'(wdt_out), 16'(e_out));
      check("model_strobe",  16'(wdt_out_strobe), 16'(e_strobe));
      check("model_frm",     16'(force_recovery_mode), 16'(e_frm));
      check("model_irq",     16'(irq), 16'(e_irq));
      check("model_csr_do",  16'(csr_do), 16'(e_do));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step1();
    @(posedge clk);
    #1;
    csr_we = 1'b0;
    ce     = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [7:0] d);
    csr_a  = TB_BASE + off;
    csr_di = d;
    csr_we = 1'b1;
    step1();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      step1();
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step1();
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] off, input logic [7:0] exp);
    csr_a = TB_BASE + off;
    #1;
    check(nm, 16'(csr_do), 16'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] roff;
    rst = 1'b1; ce = 1'b0; csr_we = 1'b0; csr_a = TB_BASE; csr_di = 8'h00;
    wdt_en_default = 2'b00;
    pulse_rst();
    pulse_rst();
    chk_on = 1'b1;

    // reset state
    rd_chk("rst_ctrl", 5'd0, 8'h00);
    rd_chk("rst_tout_l", 5'd1, 8'h30);
    rd_chk("rst_tout_h", 5'd2, 8'h00);
    rd_chk("rst_cnt_l", 5'd4, 8'h30);
    rd_chk("rst_status", 5'd8, 8'h00);
    rd_chk("undecoded", 5'd9, 8'h00);
    check("rst_irq", 16'(irq), 16'h0);

    // basic countdown
    wr(5'd0, 8'h31);
    wr(5'd1, 8'h04);
    rd_chk("staging_hold", 5'd1, 8'h30);
    wr(5'd2, 8'h00);
    rd_chk("tout_commit", 5'd1, 8'h04);
    wr(5'd3, TB_KICK);
    rd_chk("kick_reload", 5'd4, 8'h04);
    tick(4);
    check("basic_out", 16'(wdt_out), 16'h3);
    check("basic_strobe", 16'(wdt_out_strobe), 16'h3);
    step1();
    check("basic_strobe_off", 16'(wdt_out_strobe), 16'h0);
    rd_chk("basic_status", 5'd8, 8'h02);
    check("basic_irq", 16'(irq), 16'h1);
    rd_chk("kick_reads_0", 5'd3, 8'h00);
    wr(5'd8, 8'h02);
    check("w1c_irq", 16'(irq), 16'h0);

    // pre-timeout
    wr(5'd1, 8'h10); wr(5'd2, 8'h00); wr(5'd6, 8'h03); wr(5'd3, TB_KICK);
    tick(12);
    rd_chk("pre_not_yet", 5'd8, 8'h00);
    tick(1);
    rd_chk("pre_fired", 5'd8, 8'h01);
    wr(5'd8, 8'h01);
    tick(3);
    step1();
    rd_chk("pre_once", 5'd8, 8'h02);

    // window mode
    wr(5'd8, 8'h07); wr(5'd7, 8'h05); wr(5'd0, 8'h39); wr(5'd1, 8'h20); wr(5'd2, 8'h00);
    wr(5'd3, TB_KICK);
    rd_chk("win_reload", 5'd4, 8'h20);
    wr(5'd3, TB_KICK);
    rd_chk("early_cnt", 5'd4, 8'h00);
    check("early_out", 16'(wdt_out), 16'h3);
    rd_chk("early_status", 5'd8, 8'h04);
    check("early_irq", 16'(irq), 16'h1);
    step1();
    rd_chk("early_bite_status", 5'd8, 8'h06);
    wr(5'd8, 8'h07);
    wr(5'd3, TB_KICK);
    tick(27);
    rd_chk("win_edge_cnt", 5'd4, 8'h05);
    wr(5'd3, TB_KICK);
    rd_chk("win_edge_reload", 5'd4, 8'h20);
    rd_chk("win_edge_status", 5'd8, 8'h00);

    // lock and staging
    wr(5'd0, 8'h31);
    wr(5'd1, 8'h34);
    rd_chk("stage_tout_l", 5'd1, 8'h20);
    wr(5'd2, 8'h12);
    rd_chk("commit_l", 5'd1, 8'h34);
    rd_chk("commit_h", 5'd2, 8'h12);
    wr(5'd0, 8'h35);
    wr(5'd0, 8'h00);
    rd_chk("locked_ctrl", 5'd0, 8'h35);
    wr(5'd3, TB_KICK);
    rd_chk("locked_kick_h", 5'd5, 8'h12);
    tick(2);
    wr(5'd3, 8'h6a);
    rd_chk("bad_kick", 5'd4, 8'h32);
    wr(5'd2, 8'h00);
    rd_chk("locked_tout_h", 5'd2, 8'h12);

    // failsafe reset
    wdt_en_default = 2'b10;
    pulse_rst();
    rd_chk("fs_ctrl", 5'd0, 8'h02);
    wr(5'd3, TB_KICK);
    tick(48);
    check("fs_frm", 16'(force_recovery_mode), 16'h1);
    check("fs_out_oe0", 16'(wdt_out), 16'h0);
    step1();
    pulse_rst();
    rd_chk("fs_cnt_kept", 5'd4, 8'h00);
    check("fs_frm_kept", 16'(force_recovery_mode), 16'h1);
    rd_chk("fs_status_clr", 5'd8, 8'h00);
    wdt_en_default = 2'b01;
    pulse_rst();
    rd_chk("fs_cnt_kept2", 5'd4, 8'h00);
    pulse_rst();
    rd_chk("nofs_cnt_l", 5'd4, 8'h30);
    check("nofs_frm", 16'(force_recovery_mode), 16'h0);

    // W1C colliding with a new bite edge
    wr(5'd0, 8'h31); wr(5'd1, 8'h02); wr(5'd2, 8'h00); wr(5'd3, TB_KICK);
    tick(2);
    step1();
    wr(5'd8, 8'h02);
    wr(5'd3, TB_KICK);
    tick(2);
    wr(5'd8, 8'h02);
    rd_chk("collide_status", 5'd8, 8'h02);
    check("collide_irq", 16'(irq), 16'h1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      ce             = 1'($urandom_range(0, 1));
      wdt_en_default = 2'($urandom_range(0, 3));
      roff           = 5'($urandom_range(0, 10));
      csr_a          = (roff == 5'd10) ? 5'($urandom) : TB_BASE + roff;
      csr_we         = ($urandom_range(0, 2) == 0);
      case (roff)
        5'd0:    csr_di = {4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom)};
        5'd1:    csr_di = 8'($urandom_range(0, 40));
        5'd2:    csr_di = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
        5'd3:    csr_di = ($urandom_range(0, 3) != 0) ? TB_KICK : 8'($urandom);
        5'd6:    csr_di = 8'($urandom_range(0, 20));
        5'd7:    csr_di = 8'($urandom_range(0, 40));
        default: csr_di = 8'($urandom);
      endcase
      step1();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watchdog_multistage.md
# watchdog_multistage

Parametrised next-generation watchdog for the CPLD CSR bus. Widens the counter to CNT_WIDTH bits and drives up to four bite outputs. Adds a pre-timeout interrupt, a windowed-kick mode that bites on a premature kick, and a write-1-to-clear status register. It sits on the shared 5-bit CSR bus beside the other CSR blocks and is clocked with the system prescaler tick `ce`.

## Interface
- BASE_ADDR, 5'h0, CSR base address; block decodes BASE_ADDR+0 … BASE_ADDR+8.
- CNT_WIDTH, 16, counter width; legal values 8 or 16.
- NUM_OUT, 2, number of bite outputs; 1..4.
- DEFAULT_OE, all zero, NUM_OUT-bit reset value of the output enables.
- DEFAULT_TIMEOUT, all ones, CNT_WIDTH-bit reset reload value.
- KICK_VALUE, 8'h6b, magic byte that kicks.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  count tick, one clk wide.
- csr_a  in  5  CSR address.
- csr_di  in  8  CSR write data.
- csr_we  in  1  CSR write strobe, one cycle.
- csr_do  out  8  CSR read data; combinational; 0 for undecoded addresses.
- wdt_en_default  in  2  reset value of the enable bits.
- wdt_out  out  NUM_OUT  level output: oe AND bite.
- wdt_out_strobe  out  NUM_OUT  one-cycle pulse: oe AND rising edge of bite.
- force_recovery_mode  out  1  bite AND en[1].
- irq  out  1  level; high while any STATUS bit is set.

## Operation
- Register offsets from BASE_ADDR:
  - 0 CTRL: [1:0] en, [2] locked, [3] win_en, [7:4] oe (bits above NUM_OUT read 0).
  - 1 TOUT_L
  - 2 TOUT_H
  - 3 KICK (write-only, reads 0)
  - 4 CNT_L
  - 5 CNT_H
  - 6 PRETOUT (8-bit)
  - 7 WINDOW (8-bit)
  - 8 STATUS: [0] pre, [1] bite, [2] early; write-1-to-clear.
- Timeout writes:
  - CNT_WIDTH=16: a TOUT_L write goes to a staging byte. A TOUT_H write commits tout={di, staging} atomically. TOUT_L reads return committed tout[7:0].
  - CNT_WIDTH=8: a TOUT_L write commits directly. TOUT_H and CNT_H read 0 and ignore writes.
- Lock: while locked=1, writes to CTRL, TOUT_L/H, PRETOUT and WINDOW are ignored. KICK and STATUS writes still work. Only rst clears locked.
- Counter: active = |en; bite = active & (cnt==0). Counter update priority, highest first:
  1. rst & ~en[1]: cnt <= DEFAULT_TIMEOUT. In failsafe mode (en[1]=1) the counter survives reset.
  2. Early kick: cnt <= 0; set STATUS.early.
  3. Valid kick: cnt <= tout.
  4. ce & active & ~bite: cnt <= cnt-1.
- Kick classification:
  - A kick is a write to KICK with di==KICK_VALUE. Any other data is ignored.
  - Early kick = kick & win_en & active & (cnt > zero-extended WINDOW).
  - Every other kick is valid, including kicks while disabled.
- Pre-timeout:
  - Fires when ce & active & ~bite & PRETOUT!=0 & cnt == PRETOUT+1, i.e. on the decrement that lands on PRETOUT.
  - Sets STATUS.pre. Fires once per countdown.
- Bite: STATUS.bite is set on the rising edge of bite, in the same cycle as wdt_out_strobe.
- STATUS priority: in the same cycle, a set event wins over a W1C clear of the same bit.
- STATUS reset: cleared by rst regardless of failsafe mode.
- Reset values:
  - en=wdt_en_default, oe=DEFAULT_OE, tout=DEFAULT_TIMEOUT, staging=0, PRETOUT=0, WINDOW=0, win_en=0, locked=0, STATUS=0.
  - Outputs: irq=0. wdt_out, wdt_out_strobe and force_recovery_mode follow the bite equations (0 unless failsafe preserved cnt==0).

## Timing
- All state updates on posedge clk; csr_do, wdt_out and force_recovery_mode are combinational from state.
- Kick at cycle N → cnt==tout visible at N+1; bite deasserts at N+1.
- From a valid kick, bite asserts tout ce ticks later. tout=0 means immediate bite at N+1.
- Early kick at N → bite at N+1, STATUS.early=1 and irq=1 at N+1.
- wdt_out_strobe and the STATUS.bite set occur in the first cycle bite=1. The edge detector resets its history to 0 with rst.
- A W1C write at N → bit and irq clear at N+1, unless a set event occurs at N.
- Enabling (0→nonzero en) starts counting from the current cnt at the next ce.

## Test plan
- Basic countdown: rst, en=01, tout=0x0004 (write TOUT_L=04, then TOUT_H=00), kick 0x6b, 4 ce ticks → wdt_out=oe, one strobe pulse, STATUS=0x02, irq=1. W1C 0x02 → irq=0 next cycle.
- Pre-timeout: tout=0x0010, PRETOUT=0x03, kick, ticks → STATUS.pre set on the tick where cnt goes 4→3, exactly once before the bite.
- Window mode: win_en=1, WINDOW=0x05, tout=0x0020, kick at cnt=0x20 → cnt=0 and bite next cycle, STATUS=0x04. Repeat with the kick at cnt=0x05 → cnt reloads to 0x20.
- Lock and staging: write TOUT_L=0x34 only → tout unchanged. Write TOUT_H=0x12 → tout=0x1234. Set locked, write CTRL=0 → CTRL unchanged. Kick with 0x6a → no reload.
- Failsafe reset: en=10, let cnt reach 0 → force_recovery_mode=1. Pulse rst → cnt stays 0, bite persists, STATUS=0. Repeat with en=01 → cnt=DEFAULT_TIMEOUT after rst.
- Collision: W1C of STATUS.bite in the same cycle as a new bite edge → STATUS.bite stays 1, irq stays 1.
